// File: rtl/bitonic_ctrl_pkg.sv
// Shared constants, state encoding and width helpers for the bitonic batch controller.
// Module-level widths depend on each instance's parameters, so they are derived through
// the helper functions below rather than fixed package constants.
package bitonic_ctrl_pkg;

    // Default configuration: 512 lanes of 64-bit records, 32-bit key, two output batches.
    localparam int unsigned P_LOG_DEF       = 9;
    localparam int unsigned DATW_DEF        = 64;
    localparam int unsigned KEYW_DEF        = 32;
    localparam int unsigned OUT_BATCHES_DEF = 2;

    // Pad records are all ones; replicate this bit to the record width.
    localparam logic PAD_BIT = 1'b1;

    // Fill-side FSM: collect records into lanes, then wait for a credit to issue.
    typedef enum logic {
        StFill  = 1'b0,
        StIssue = 1'b1
    } fill_state_e;

    // Number of lanes in a batch (N).
    function automatic int unsigned lane_count(input int unsigned p_log);
        return 1 << p_log;
    endfunction

    // Width of a record count; must hold N itself, hence P_LOG+1 bits.
    function automatic int unsigned cnt_width(input int unsigned p_log);
        return p_log + 1;
    endfunction

    // Width of the credit counter, which ranges over 0..OUT_BATCHES.
    function automatic int unsigned credit_width(input int unsigned out_batches);
        return $clog2(out_batches + 1);
    endfunction

endpackage

// File: rtl/bitonic_out_buf.sv
// Output side of the batch controller: holds sorted batches from the sorter, remembers how
// many real records each batch carries, and serializes them one lane at a time.
// Popping a batch returns one credit to the issue side.
module bitonic_out_buf
    import bitonic_ctrl_pkg::*;
#(
    parameter int unsigned P_LOG       = P_LOG_DEF,
    parameter int unsigned DATW        = DATW_DEF,
    parameter int unsigned OUT_BATCHES = OUT_BATCHES_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // Real-record count of each issued batch, pushed in issue order.
    input  logic                      cnt_push_i,
    input  logic [P_LOG:0]            cnt_i,
    // Sorted batch from the sorter.
    input  logic [(DATW<<P_LOG)-1:0]  dot_i,
    input  logic                      doten_i,
    // Record stream out.
    output logic [DATW-1:0]           out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    // One-cycle pulse when a batch leaves the buffer.
    output logic                      credit_ret_o
);

    localparam int unsigned N    = lane_count(P_LOG);
    localparam int unsigned CNTW = cnt_width(P_LOG);
    localparam int unsigned OCCW = credit_width(OUT_BATCHES);
    localparam int unsigned PTRW = (OUT_BATCHES > 1) ? $clog2(OUT_BATCHES) : 1;

    typedef logic [N-1:0][DATW-1:0] batch_t;

    batch_t          buf_mem [OUT_BATCHES];
    logic [CNTW-1:0] cnt_mem [OUT_BATCHES];

    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]  cw_ptr_q, cw_ptr_d;
    logic [OCCW-1:0]  occ_q, occ_d;
    logic [P_LOG-1:0] lane_q, lane_d;

    logic            out_valid;
    logic            out_last;
    logic            out_fire;
    logic            pop;
    logic [CNTW-1:0] head_cnt;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(OUT_BATCHES - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // The count FIFO and the batch buffer see batches in the same order, so one read
    // pointer serves both.
    assign head_cnt  = cnt_mem[rd_ptr_q];
    assign out_valid = (occ_q != '0);
    assign out_last  = ({1'b0, lane_q} == (head_cnt - CNTW'(1)));
    assign out_fire  = out_valid && out_ready_i;
    assign pop       = out_fire && out_last;

    assign out_data_o   = buf_mem[rd_ptr_q][lane_q];
    assign out_valid_o  = out_valid;
    assign out_last_o   = out_valid && out_last;
    assign credit_ret_o = pop;

    // Next-state for pointers, occupancy and the serializer lane.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cw_ptr_d = cw_ptr_q;
        occ_d    = occ_q + OCCW'(doten_i) - OCCW'(pop);
        lane_d   = lane_q;
        if (doten_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (cnt_push_i) begin
            cw_ptr_d = ptr_inc(cw_ptr_q);
        end
        if (out_fire) begin
            lane_d = pop ? '0 : lane_q + P_LOG'(1);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cw_ptr_q <= '0;
            occ_q    <= '0;
            lane_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cw_ptr_q <= cw_ptr_d;
            occ_q    <= occ_d;
            lane_q   <= lane_d;
        end
    end

    // Data storage; no reset needed, entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (doten_i && !rst_i) begin
            buf_mem[wr_ptr_q] <= dot_i;
        end
        if (cnt_push_i && !rst_i) begin
            cnt_mem[cw_ptr_q] <= cnt_i;
        end
    end

    // Credits guarantee a free slot for every sorted batch.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        doten_i |-> (occ_q != OCCW'(OUT_BATCHES)));

endmodule

// File: rtl/bitonic_batch_ctrl.sv
// Front/back-end scheduler for the bitonic sorter: packs incoming records into lanes,
// pads short batches, issues a batch only when an output slot is reserved by a credit,
// and hands sorted batches to the output buffer for serialization.
module bitonic_batch_ctrl
    import bitonic_ctrl_pkg::*;
#(
    parameter int unsigned P_LOG       = P_LOG_DEF,
    parameter int unsigned DATW        = DATW_DEF,
    parameter int unsigned KEYW        = KEYW_DEF,
    parameter int unsigned OUT_BATCHES = OUT_BATCHES_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATW-1:0]           IN_DATA,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      IN_LAST,
    output logic [(DATW<<P_LOG)-1:0]  SRT_DIN,
    output logic                      SRT_DINEN,
    input  logic [(DATW<<P_LOG)-1:0]  SRT_DOT,
    input  logic                      SRT_DOTEN,
    output logic [DATW-1:0]           OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic                      OUT_LAST,
    output logic                      BUSY
);

    localparam int unsigned N     = lane_count(P_LOG);
    localparam int unsigned CNTW  = cnt_width(P_LOG);
    localparam int unsigned CREDW = credit_width(OUT_BATCHES);

    localparam logic [DATW-1:0]  PAD       = {DATW{PAD_BIT}};
    localparam logic [CREDW-1:0] CRED_FULL = CREDW'(OUT_BATCHES);

    typedef logic [N-1:0][DATW-1:0] batch_t;

    fill_state_e      state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    batch_t           lanes_q, lanes_d;
    batch_t           din_q, din_d;
    logic             dinen_q, dinen_d;
    logic             in_ready_q, in_ready_d;
    logic [CREDW-1:0] credit_q, credit_d;
    logic             busy_q, busy_d;

    logic accept;
    logic credit_ret;

    assign accept = IN_VALID && in_ready_q;

    // Fill FSM, packer and credit counter next-state; outputs are derived from next state
    // so that every port is driven straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        din_d   = din_q;
        case (state_q)
            StFill: begin
                if (accept) begin
                    lanes_d[cnt_q[P_LOG-1:0]] = IN_DATA;
                    cnt_d                     = cnt_q + CNTW'(1);
                    if ((cnt_q == CNTW'(N - 1)) || IN_LAST) begin
                        // Unused lanes still hold PAD, so the snapshot is already padded.
                        state_d = StIssue;
                        din_d   = lanes_d;
                    end
                end
            end
            StIssue: begin
                if (dinen_q) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    lanes_d = {N{PAD}};
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase

        // A credit returned this cycle is visible to the issue decision for next cycle.
        credit_d   = credit_q - CREDW'(dinen_q) + CREDW'(credit_ret);
        dinen_d    = (state_d == StIssue) && (credit_d != '0);
        in_ready_d = (state_d == StFill);
        busy_d     = (cnt_d != '0) || (state_d == StIssue) || (credit_d != CRED_FULL);
    end

    // Fill-side state and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            lanes_q    <= {N{PAD}};
            din_q      <= '0;
            dinen_q    <= 1'b0;
            in_ready_q <= 1'b0;
            credit_q   <= CRED_FULL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lanes_q    <= lanes_d;
            din_q      <= din_d;
            dinen_q    <= dinen_d;
            in_ready_q <= in_ready_d;
            credit_q   <= credit_d;
            busy_q     <= busy_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign SRT_DIN   = din_q;
    assign SRT_DINEN = dinen_q;
    assign BUSY      = busy_q;

    bitonic_out_buf #(
        .P_LOG       (P_LOG),
        .DATW        (DATW),
        .OUT_BATCHES (OUT_BATCHES)
    ) u_out_buf (
        .clk_i        (CLK),
        .rst_i        (RST),
        .cnt_push_i   (dinen_q),
        .cnt_i        (cnt_q),
        .dot_i        (SRT_DOT),
        .doten_i      (SRT_DOTEN),
        .out_data_o   (OUT_DATA),
        .out_valid_o  (OUT_VALID),
        .out_ready_i  (OUT_READY),
        .out_last_o   (OUT_LAST),
        .credit_ret_o (credit_ret)
    );

    // All-ones keys mark padding; a real record carrying one would be dropped as a pad.
    a_no_pad_key : assert property (@(posedge CLK) disable iff (RST)
        accept |-> (IN_DATA[KEYW-1:0] != {KEYW{1'b1}}));

endmodule

// File: tb/tb_bitonic_batch_ctrl.sv
// Directed bench for bitonic_batch_ctrl with a 4-lane behavioural sorter (3-cycle latency).
// Record upper half = running record index, lower half = key.
module tb_bitonic_batch_ctrl;

    localparam int unsigned P_LOG = 2;
    localparam int unsigned DATW  = 64;
    localparam int unsigned KEYW  = 32;
    localparam int unsigned OB    = 2;
    localparam int unsigned N     = 4;

    typedef logic [N-1:0][DATW-1:0] batch_t;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [DATW-1:0]        IN_DATA = '0;
    logic                   IN_VALID = 1'b0;
    logic                   IN_READY;
    logic                   IN_LAST = 1'b0;
    logic [(DATW<<P_LOG)-1:0] SRT_DIN;
    logic                   SRT_DINEN;
    logic [(DATW<<P_LOG)-1:0] SRT_DOT;
    logic                   SRT_DOTEN;
    logic [DATW-1:0]        OUT_DATA;
    logic                   OUT_VALID;
    logic                   OUT_READY = 1'b0;
    logic                   OUT_LAST;
    logic                   BUSY;

    bitonic_batch_ctrl #(
        .P_LOG       (P_LOG),
        .DATW        (DATW),
        .KEYW        (KEYW),
        .OUT_BATCHES (OB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_LAST   (IN_LAST),
        .SRT_DIN   (SRT_DIN),
        .SRT_DINEN (SRT_DINEN),
        .SRT_DOT   (SRT_DOT),
        .SRT_DOTEN (SRT_DOTEN),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural sorter ----------------
    function automatic batch_t sort4(input batch_t d);
        batch_t          r;
        logic [DATW-1:0] t;
        r = d;
        for (int i = 0; i < N - 1; i++) begin
            for (int j = 0; j < N - 1 - i; j++) begin
                if (r[j][KEYW-1:0] > r[j+1][KEYW-1:0]) begin
                    t      = r[j];
                    r[j]   = r[j+1];
                    r[j+1] = t;
                end
            end
        end
        return r;
    endfunction

    batch_t sp0 = '0, sp1 = '0, sp2 = '0;
    logic   sv0 = 1'b0, sv1 = 1'b0, sv2 = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            sv0 <= 1'b0;
            sv1 <= 1'b0;
            sv2 <= 1'b0;
        end else begin
            sv0 <= SRT_DINEN;
            sp0 <= sort4(SRT_DIN);
            sv1 <= sv0;
            sp1 <= sp0;
            sv2 <= sv1;
            sp2 <= sp1;
        end
    end

    assign SRT_DOTEN = sv2;
    assign SRT_DOT   = sp2;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int              cyc = 0;
    logic [DATW-1:0] oq_data[$];
    logic            oq_last[$];
    int              dinen_cyc[$];
    batch_t          dinen_din[$];
    int              hs_last_cyc[$];
    logic            prev_stall = 1'b0;
    logic [DATW-1:0] prev_data = '0;
    logic            prev_last = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", OUT_VALID, 1'b1);
                check("stall_data", OUT_DATA, prev_data);
                check("stall_last", OUT_LAST, prev_last);
            end
            if (OUT_VALID && OUT_READY) begin
                oq_data.push_back(OUT_DATA);
                oq_last.push_back(OUT_LAST);
                if (OUT_LAST) hs_last_cyc.push_back(cyc);
            end
            if (SRT_DINEN) begin
                dinen_cyc.push_back(cyc);
                dinen_din.push_back(SRT_DIN);
            end
            prev_stall <= OUT_VALID && !OUT_READY;
            prev_data  <= OUT_DATA;
            prev_last  <= OUT_LAST;
        end
    end

    // ---------------- helpers ----------------
    int          acc_cyc = 0;
    logic [31:0] rec_idx = '0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        oq_data.delete();
        oq_last.delete();
        dinen_cyc.delete();
        dinen_din.delete();
        hs_last_cyc.delete();
    endtask

    task automatic send(input logic [31:0] key, input logic last);
        int budget;
        budget   = 0;
        IN_DATA  = {rec_idx, key};
        IN_VALID = 1'b1;
        IN_LAST  = last;
        @(negedge CLK);
        while (!IN_READY && budget < 100) begin
            @(negedge CLK);
            budget++;
        end
        check("in_ready_wait", IN_READY, 1'b1);
        acc_cyc = cyc;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        rec_idx++;
    endtask

    task automatic wait_out(input int n, input string tag);
        int budget;
        budget = 0;
        while (oq_data.size() < n && budget < 200) begin
            tick();
            budget++;
        end
        ticks(6);
        check(tag, oq_data.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 0;
        while (BUSY && budget < 200) begin
            tick();
            budget++;
        end
        check(tag, BUSY, 1'b0);
    endtask

    task automatic expect_out(input logic [31:0] idx, input logic [31:0] key, input logic last,
                              input string tag);
        logic [DATW-1:0] d;
        logic            l;
        d = '1;
        l = ~last;
        if (oq_data.size() > 0) begin
            d = oq_data.pop_front();
            l = oq_last.pop_front();
        end
        check({tag, "_data"}, d, {idx, key});
        check({tag, "_last"}, l, last);
    endtask

    function automatic int dinen_cyc_at(input int i);
        return (i < dinen_cyc.size()) ? dinen_cyc[i] : -1;
    endfunction

    function automatic int hs_cyc_at(input int i);
        return (i < hs_last_cyc.size()) ? hs_last_cyc[i] : -2;
    endfunction

    function automatic batch_t din_at(input int i);
        return (i < dinen_din.size()) ? dinen_din[i] : '0;
    endfunction

    // ---------------- directed sequence ----------------
    logic [31:0] base;
    batch_t      eb;
    int          t_acc;
    int          budget;

    initial begin
        // Reset state
        ticks(3);
        check("rst_in_ready", IN_READY, 1'b0);
        check("rst_dinen", SRT_DINEN, 1'b0);
        check("rst_din", SRT_DIN, '0);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_out_last", OUT_LAST, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        RST = 1'b0;
        tick();
        check("rel_in_ready", IN_READY, 1'b1);

        // 1. Full batch 4,3,2,1
        clear_mon();
        OUT_READY = 1'b1;
        base = rec_idx;
        send(32'd4, 1'b0);
        send(32'd3, 1'b0);
        send(32'd2, 1'b0);
        send(32'd1, 1'b0);
        t_acc = acc_cyc;
        wait_out(4, "t1_out_count");
        check("t1_dinen_count", dinen_cyc.size(), 1);
        check("t1_dinen_cycle", dinen_cyc_at(0), t_acc + 1);
        eb[0] = {base, 32'd4};
        eb[1] = {base + 32'd1, 32'd3};
        eb[2] = {base + 32'd2, 32'd2};
        eb[3] = {base + 32'd3, 32'd1};
        check("t1_din", din_at(0), eb);
        expect_out(base + 32'd3, 32'd1, 1'b0, "t1_o0");
        expect_out(base + 32'd2, 32'd2, 1'b0, "t1_o1");
        expect_out(base + 32'd1, 32'd3, 1'b0, "t1_o2");
        expect_out(base, 32'd4, 1'b1, "t1_o3");
        wait_idle("t1_idle");

        // 2. Partial batch 7,5 (IN_LAST on 5)
        clear_mon();
        base = rec_idx;
        send(32'd7, 1'b0);
        send(32'd5, 1'b1);
        wait_out(2, "t2_out_count");
        eb[0] = {base, 32'd7};
        eb[1] = {base + 32'd1, 32'd5};
        eb[2] = '1;
        eb[3] = '1;
        check("t2_din", din_at(0), eb);
        expect_out(base + 32'd1, 32'd5, 1'b0, "t2_o0");
        expect_out(base, 32'd7, 1'b1, "t2_o1");
        wait_idle("t2_idle");

        // 3. Credit stall with three full batches
        clear_mon();
        OUT_READY = 1'b0;
        base = rec_idx;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) begin
                send(32'(10 * (b + 1) + i), 1'b0);
            end
        end
        ticks(12);
        check("t3_two_issues", dinen_cyc.size(), 2);
        check("t3_in_ready_held", IN_READY, 1'b0);
        check("t3_busy", BUSY, 1'b1);
        check("t3_head_valid", OUT_VALID, 1'b1);
        check("t3_head_data", OUT_DATA, {base, 32'd10});
        clear_mon();
        OUT_READY = 1'b1;
        wait_out(12, "t3_out_count");
        check("t3_third_issue", dinen_cyc.size(), 1);
        check("t3_issue_after_credit", dinen_cyc_at(0), hs_cyc_at(0) + 1);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) begin
                expect_out(base + 32'(4 * b + i), 32'(10 * (b + 1) + i), (i == 3), "t3_o");
            end
        end
        wait_idle("t3_idle");

        // 4. Backpressure toggle over batch 8,6,4,2
        clear_mon();
        OUT_READY = 1'b0;
        base = rec_idx;
        send(32'd8, 1'b0);
        send(32'd6, 1'b0);
        send(32'd4, 1'b0);
        send(32'd2, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            OUT_READY = ~OUT_READY;
        end
        OUT_READY = 1'b1;
        wait_out(4, "t4_out_count");
        expect_out(base + 32'd3, 32'd2, 1'b0, "t4_o0");
        expect_out(base + 32'd2, 32'd4, 1'b0, "t4_o1");
        expect_out(base + 32'd1, 32'd6, 1'b0, "t4_o2");
        expect_out(base, 32'd8, 1'b1, "t4_o3");
        wait_idle("t4_idle");

        // 5. Single record 9
        clear_mon();
        base = rec_idx;
        send(32'd9, 1'b1);
        wait_out(1, "t5_out_count");
        eb[0] = {base, 32'd9};
        eb[1] = '1;
        eb[2] = '1;
        eb[3] = '1;
        check("t5_din", din_at(0), eb);
        expect_out(base, 32'd9, 1'b1, "t5_o0");
        wait_idle("t5_idle");

        // 6. Reset mid-operation
        clear_mon();
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(40 + i), 1'b0);
        budget = 0;
        while (!OUT_VALID && budget < 50) begin
            tick();
            budget++;
        end
        check("t6_buffered", OUT_VALID, 1'b1);
        send(32'd50, 1'b0);
        send(32'd51, 1'b0);
        check("t6_busy_before", BUSY, 1'b1);
        RST = 1'b1;
        tick();
        check("t6_rst_in_ready", IN_READY, 1'b0);
        check("t6_rst_out_valid", OUT_VALID, 1'b0);
        check("t6_rst_busy", BUSY, 1'b0);
        check("t6_rst_din", SRT_DIN, '0);
        tick();
        RST = 1'b0;
        tick();
        check("t6_rel_in_ready", IN_READY, 1'b1);
        check("t6_rel_out_valid", OUT_VALID, 1'b0);
        check("t6_rel_busy", BUSY, 1'b0);
        clear_mon();
        ticks(6);
        check("t6_no_issue", dinen_cyc.size(), 0);
        check("t6_still_empty", OUT_VALID, 1'b0);
        OUT_READY = 1'b1;
        base = rec_idx;
        send(32'd4, 1'b0);
        send(32'd3, 1'b0);
        send(32'd2, 1'b0);
        send(32'd1, 1'b0);
        t_acc = acc_cyc;
        wait_out(4, "t6_out_count");
        check("t6_dinen_cycle", dinen_cyc_at(0), t_acc + 1);
        expect_out(base + 32'd3, 32'd1, 1'b0, "t6_o0");
        expect_out(base + 32'd2, 32'd2, 1'b0, "t6_o1");
        expect_out(base + 32'd1, 32'd3, 1'b0, "t6_o2");
        expect_out(base, 32'd4, 1'b1, "t6_o3");
        wait_idle("t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
